// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive channel.
// FSM state encoding, error-bit positions, data-length codes and the FIFO entry layout.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    localparam int ERR_FRAME  = 0;
    localparam int ERR_PARITY = 1;
    localparam int ERR_BREAK  = 2;

    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    // Index of the last data bit for a data_bits code (code 0 -> 5 bits -> index 4).
    function automatic logic [2:0] last_bit_index(input logic [1:0] code);
        return {1'b0, code} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO.
// The head entry is always presented on rdata; an extra pointer MSB separates full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers; they wrap naturally with the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; the slot freed by a simultaneous pop is safe to reuse when full.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive channel: synchroniser, oversample tick generator, frame FSM,
// per-character error tagging and an FWFT receive FIFO.
// Optional idle timeout is built only when UART_RX_TIMEOUT_EN is defined;
// otherwise timeout_flag is tied low.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx_en,
    input  logic [1:0]                    data_bits,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop_bit_twice,
    input  logic                          UART_RXD,
    input  logic                          rd_en,
    input  logic                          clr_errors,
    output logic [7:0]                    rd_data,
    output logic [2:0]                    rd_err,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          overrun,
    output logic                          rx_busy,
    output logic                          timeout_flag
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] TICK_S0   = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0] TICK_S1   = OS_W'(OVERSAMPLE/2);
    localparam logic [OS_W-1:0] TICK_S2   = OS_W'(OVERSAMPLE/2 + 1);
    localparam logic [OS_W-1:0] TICK_LAST = OS_W'(OVERSAMPLE - 1);

    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;
    logic             fall_edge;
    logic             start_fire;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [OS_W-1:0]  tick_cnt;
    logic             mid_tick;
    logic             end_tick;

    rx_state_t        state;
    logic [1:0]       bits_cfg;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             samp0;
    logic             samp1;
    logic             bit_val;
    logic             par_acc;
    logic             all_zero;
    logic             frame_err;
    logic             par_err;
    logic             brk_err;
    logic [2:0]       final_err;
    logic             push_req;
    rx_entry_t        push_entry;
    rx_entry_t        head;

    assign fall_edge  = rxd_prev && !rxd_sync;
    assign start_fire = (state == ST_IDLE) && rx_en && fall_edge;
    assign tick       = (div_cnt == baud_div);
    assign mid_tick   = tick && (tick_cnt == TICK_S2);
    assign end_tick   = tick && (tick_cnt == TICK_LAST);
    assign bit_val    = (samp0 & samp1) | (samp0 & rxd_sync) | (samp1 & rxd_sync);
    assign rx_busy    = (state != ST_IDLE);

    // Two-flop synchroniser for the asynchronous pin plus one delayed copy for edge detection.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= UART_RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Oversample tick divider, re-aligned to the start edge so samples land mid-bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_cnt <= '0;
        end else if (start_fire || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Error bits for the character being closed on the final stop-bit sample.
    always_comb begin
        final_err             = '0;
        final_err[ERR_FRAME]  = frame_err | ~bit_val;
        final_err[ERR_PARITY] = par_err;
        final_err[ERR_BREAK]  = brk_err | ((state == ST_STOP1) & all_zero & ~bit_val);
    end

    // Frame FSM: walks start, data, parity and stop bits, then requests a FIFO push.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            samp0      <= 1'b1;
            samp1      <= 1'b1;
            bits_cfg   <= DATA_BITS_8;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_acc    <= 1'b0;
            all_zero   <= 1'b1;
            frame_err  <= 1'b0;
            par_err    <= 1'b0;
            brk_err    <= 1'b0;
            push_req   <= 1'b0;
            push_entry <= '0;
        end else begin
            push_req <= 1'b0;
            if (tick) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick && (tick_cnt == TICK_S0)) samp0 <= rxd_sync;
            if (tick && (tick_cnt == TICK_S1)) samp1 <= rxd_sync;

            if ((state != ST_IDLE) && !rx_en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_fire) begin
                            state     <= ST_START;
                            tick_cnt  <= '0;
                            bits_cfg  <= data_bits;
                            bit_idx   <= '0;
                            shift_reg <= '0;
                            par_acc   <= 1'b0;
                            all_zero  <= 1'b1;
                            frame_err <= 1'b0;
                            par_err   <= 1'b0;
                            brk_err   <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (mid_tick && bit_val) begin
                            state <= ST_IDLE;
                        end else if (end_tick) begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (mid_tick) begin
                            shift_reg[bit_idx] <= bit_val;
                            par_acc            <= par_acc ^ bit_val;
                            if (bit_val) all_zero <= 1'b0;
                        end
                        if (end_tick) begin
                            if (bit_idx == last_bit_index(bits_cfg)) begin
                                state <= parity_en ? ST_PARITY : ST_STOP1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (mid_tick) begin
                            par_err <= ((par_acc ^ bit_val) != parity_odd);
                            if (bit_val) all_zero <= 1'b0;
                        end
                        if (end_tick) state <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        if (mid_tick) begin
                            if (!bit_val) frame_err <= 1'b1;
                            if (all_zero && !bit_val) brk_err <= 1'b1;
                            if (!stop_bit_twice) begin
                                push_req   <= 1'b1;
                                push_entry <= rx_entry_t'({final_err, shift_reg});
                                state      <= ST_IDLE;
                            end
                        end else if (end_tick) begin
                            state <= ST_STOP2;
                        end
                    end
                    ST_STOP2: begin
                        if (mid_tick) begin
                            push_req   <= 1'b1;
                            push_entry <= rx_entry_t'({final_err, shift_reg});
                            state      <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push_req),
        .pop   (rd_en),
        .wdata (push_entry),
        .rdata (head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign rd_data = rx_empty ? 8'h00 : head.data;
    assign rd_err  = rx_empty ? 3'b000 : head.err;

    // Sticky overrun: a push arrived while full and no pop made room for it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            overrun <= 1'b0;
        end else begin
            if (clr_errors) overrun <= 1'b0;
            if (push_req && rx_full && !rd_en) overrun <= 1'b1;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS * OVERSAMPLE);

    logic [31:0] to_cnt;
    logic        to_flag;
    logic        to_clear;

    assign to_clear     = rd_en || start_fire || rx_empty;
    assign timeout_flag = to_flag;

    // Count idle oversample ticks while data waits in the FIFO; flag once the limit is hit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (to_clear) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (tick && (state == ST_IDLE) && (to_cnt != TO_LIMIT)) begin
            to_cnt <= to_cnt + 32'd1;
            if (to_cnt == TO_LIMIT - 32'd1) to_flag <= 1'b1;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core with baud_div=3 (64 PCLK per bit).
// Stimulus pushes hand-computed expected entries into a queue; a monitor pops
// and compares whenever the FIFO presents a head entry and monitoring is enabled.
`timescale 1ns/1ps
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    localparam int FIFO_DEPTH   = 16;
    localparam int OVERSAMPLE   = 16;
    localparam int DIV_W        = 16;
    localparam int TIMEOUT_BITS = 32;
    localparam int BIT          = 64;

    logic                          PCLK = 1'b0;
    logic                          PRESETn = 1'b0;
    logic [DIV_W-1:0]              baud_div = 16'd3;
    logic                          rx_en = 1'b1;
    logic [1:0]                    data_bits = 2'd3;
    logic                          parity_en = 1'b0;
    logic                          parity_odd = 1'b0;
    logic                          stop_bit_twice = 1'b0;
    logic                          UART_RXD = 1'b1;
    logic                          rd_en;
    logic                          clr_errors = 1'b0;
    logic [7:0]                    rd_data;
    logic [2:0]                    rd_err;
    logic                          rx_empty;
    logic                          rx_full;
    logic [$clog2(FIFO_DEPTH):0]   rx_level;
    logic                          overrun;
    logic                          rx_busy;
    logic                          timeout_flag;

    logic      mon_en = 1'b0;
    logic      mon_rd = 1'b0;
    logic      tb_rd  = 1'b0;
    rx_entry_t exp_q[$];
    rx_entry_t e_main;
    rx_entry_t e_mon;
    int        checks = 0;
    int        fails  = 0;

    assign rd_en = mon_rd | tb_rd;

    uart_rx_core #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .OVERSAMPLE   (OVERSAMPLE),
        .DIV_W        (DIV_W),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .baud_div       (baud_div),
        .rx_en          (rx_en),
        .data_bits      (data_bits),
        .parity_en      (parity_en),
        .parity_odd     (parity_odd),
        .stop_bit_twice (stop_bit_twice),
        .UART_RXD       (UART_RXD),
        .rd_en          (rd_en),
        .clr_errors     (clr_errors),
        .rd_data        (rd_data),
        .rd_err         (rd_err),
        .rx_empty       (rx_empty),
        .rx_full        (rx_full),
        .rx_level       (rx_level),
        .overrun        (overrun),
        .rx_busy        (rx_busy),
        .timeout_flag   (timeout_flag)
    );

    // 10 ns PCLK
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic driveBit(input logic v);
        UART_RXD = v;
        repeat (BIT) @(negedge PCLK);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int nbits, input logic use_par,
                                 input logic par_bit, input logic stop1, input logic use_stop2,
                                 input logic stop2);
        driveBit(1'b0);
        for (int i = 0; i < nbits; i++) driveBit(data[i]);
        if (use_par) driveBit(par_bit);
        driveBit(stop1);
        if (use_stop2) driveBit(stop2);
        if (UART_RXD == 1'b0) driveBit(1'b1);
    endtask

    task automatic expectChar(input logic [2:0] err, input logic [7:0] data);
        exp_q.push_back(rx_entry_t'({err, data}));
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !rx_empty) && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        if (exp_q.size() != 0 || !rx_empty) failNow(name);
    endtask

    // Monitor: compare the FIFO head against the scoreboard and pop it.
    initial begin
        forever begin
            @(negedge PCLK);
            mon_rd = 1'b0;
            if (mon_en && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_entry: got data 0x%0h err 0x%0h, expected none", rd_data, rd_err);
                end else begin
                    e_mon = exp_q.pop_front();
                    checkOutput("mon_data", 32'(rd_data), 32'(e_mon.data));
                    checkOutput("mon_err", 32'(rd_err), 32'(e_mon.err));
                end
                mon_rd = 1'b1;
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic busy_seen;
        int   n;

        // Reset state
        repeat (3) @(negedge PCLK);
        checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
        checkOutput("rst_rd_err", 32'(rd_err), 32'h0);
        checkOutput("rst_rx_empty", 32'(rx_empty), 32'h1);
        checkOutput("rst_rx_full", 32'(rx_full), 32'h0);
        checkOutput("rst_rx_level", 32'(rx_level), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);
        checkOutput("rst_rx_busy", 32'(rx_busy), 32'h0);
        checkOutput("rst_timeout", 32'(timeout_flag), 32'h0);
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);

        // 8N1 clean character
        $display("[TB] 8N1 clean character");
        expectChar(3'b000, 8'hA5);
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("8n1_empty", 32'(rx_empty), 32'h0);
        checkOutput("8n1_level", 32'(rx_level), 32'h1);
        checkOutput("8n1_data", 32'(rd_data), 32'hA5);
        checkOutput("8n1_err", 32'(rd_err), 32'h0);
        mon_en = 1'b1;
        drain("8n1_drain", 200);

        // 7E1 with forced wrong parity bit
        $display("[TB] 7E1 parity error");
        data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b0; stop_bit_twice = 1'b0;
        expectChar(3'b010, 8'h35);
        applyStimulus(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("7e1_drain", 200);

        // 5O2: good parity, then bad second stop bit
        $display("[TB] 5O2 frames");
        data_bits = 2'd0; parity_en = 1'b1; parity_odd = 1'b1; stop_bit_twice = 1'b1;
        expectChar(3'b000, 8'h13);
        applyStimulus(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        expectChar(3'b001, 8'h0C);
        applyStimulus(8'h0C, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drain("5o2_drain", 200);

        // Break: line low for 12 bit-times in 8N1
        $display("[TB] break");
        data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; stop_bit_twice = 1'b0;
        expectChar(3'b101, 8'h00);
        UART_RXD = 1'b0;
        repeat (12 * BIT) @(negedge PCLK);
        UART_RXD = 1'b1;
        repeat (3 * BIT) @(negedge PCLK);
        drain("break_drain", 200);
        checkOutput("break_busy", 32'(rx_busy), 32'h0);
        checkOutput("break_empty", 32'(rx_empty), 32'h1);

        // False start: 10-cycle glitch
        $display("[TB] false start");
        busy_seen = 1'b0;
        UART_RXD = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (i == 9) UART_RXD = 1'b1;
            if (rx_busy) busy_seen = 1'b1;
        end
        checkOutput("glitch_busy_pulse", 32'(busy_seen), 32'h1);
        repeat (2 * BIT) @(negedge PCLK);
        checkOutput("glitch_busy_end", 32'(rx_busy), 32'h0);
        checkOutput("glitch_no_push", 32'(rx_empty), 32'h1);

        // Mid-frame disable with one character already stored
        $display("[TB] mid-frame disable");
        mon_en = 1'b0;
        expectChar(3'b000, 8'h3C);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b1);
        driveBit(1'b1);
        UART_RXD = 1'b0;
        repeat (BIT / 2) @(negedge PCLK);
        checkOutput("dis_busy_before", 32'(rx_busy), 32'h1);
        rx_en = 1'b0;
        repeat (2) @(negedge PCLK);
        checkOutput("dis_busy_after", 32'(rx_busy), 32'h0);
        checkOutput("dis_level", 32'(rx_level), 32'h1);
        UART_RXD = 1'b1;
        repeat (BIT) @(negedge PCLK);
        rx_en = 1'b1;
        repeat (2 * BIT) @(negedge PCLK);
        checkOutput("dis_level_later", 32'(rx_level), 32'h1);
        mon_en = 1'b1;
        drain("dis_drain", 200);

        // Overrun: 17 characters without reading
        $display("[TB] overrun");
        mon_en = 1'b0;
        repeat (4) @(negedge PCLK);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expectChar(3'b000, 8'(8'h10 + i));
            applyStimulus(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("ovr_full", 32'(rx_full), 32'h1);
        checkOutput("ovr_level", 32'(rx_level), 32'd16);
        checkOutput("ovr_flag", 32'(overrun), 32'h1);
        checkOutput("ovr_head", 32'(rd_data), 32'h10);
        clr_errors = 1'b1;
        @(negedge PCLK);
        clr_errors = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 32'h0);

        // Push and pop in the same cycle while full
        expectChar(3'b000, 8'h22);
        fork
            applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin : corner
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 1000 && !seen; i++) begin
                    @(negedge PCLK);
                    if (dut.push_req) seen = 1'b1;
                end
                if (!seen) begin
                    failNow("corner_push_wait");
                end else begin
                    e_main = exp_q.pop_front();
                    checkOutput("corner_head", 32'(rd_data), 32'(e_main.data));
                    tb_rd = 1'b1;
                    @(negedge PCLK);
                    tb_rd = 1'b0;
                end
            end
        join
        checkOutput("corner_level", 32'(rx_level), 32'd16);
        checkOutput("corner_overrun", 32'(overrun), 32'h0);
        checkOutput("corner_full", 32'(rx_full), 32'h1);
        mon_en = 1'b1;
        drain("corner_drain", 300);

`ifdef UART_RX_TIMEOUT_EN
        // Idle timeout with one unread character
        $display("[TB] timeout");
        mon_en = 1'b0;
        repeat (4) @(negedge PCLK);
        expectChar(3'b000, 8'h5A);
        applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("to_early", 32'(timeout_flag), 32'h0);
        n = 0;
        while (!timeout_flag && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        if (!timeout_flag) begin
            failNow("to_wait");
        end else begin
            checkOutput("to_window", 32'((n >= 1990) && (n <= 2060)), 32'h1);
        end
        e_main = exp_q.pop_front();
        checkOutput("to_data", 32'(rd_data), 32'(e_main.data));
        tb_rd = 1'b1;
        @(negedge PCLK);
        tb_rd = 1'b0;
        checkOutput("to_cleared", 32'(timeout_flag), 32'h0);
`else
        n = 0;
`endif

        repeat (10) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive channel: oversampled line sampling, configurable frame format (5–8 data bits, optional even/odd parity, 1 or 2 stop bits), per-character error tagging and a parametrised first-word-fall-through receive FIFO. It sits between the `UART_RXD` pin and the APB register interface and replaces the separate start-bit detector, temporary flops, RX FIFO, RX FSM and shift register with one self-contained channel. Unlike the previous path, it adds break detection, an overrun flag, a receive level count and an optional idle timeout.

## Interface
- `FIFO_DEPTH`, 16 — RX FIFO entries; power of two, ≥2.
- `OVERSAMPLE`, 16 — oversample ticks per bit; even, ≥8.
- `DIV_W`, 16 — width of `baud_div`.
- `TIMEOUT_BITS`, 32 — idle bit-times before timeout; used only when `UART_RX_TIMEOUT_EN` is defined.
- `PCLK`  in  1  clock.
- `PRESETn`  in  1  asynchronous active-low reset.
- `baud_div`  in  DIV_W  PCLK cycles per oversample tick, minus 1.
- `rx_en`  in  1  receiver enable.
- `data_bits`  in  2  data bit count: 0→5, 1→6, 2→7, 3→8.
- `parity_en`  in  1  parity bit present.
- `parity_odd`  in  1  1 = odd parity, 0 = even.
- `stop_bit_twice`  in  1  two stop bits.
- `UART_RXD`  in  1  serial input; asynchronous.
- `rd_en`  in  1  pop the FIFO head.
- `clr_errors`  in  1  clear sticky `overrun`.
- `rd_data`  out  8  FIFO head data, right-justified, zero-filled.
- `rd_err`  out  3  FIFO head errors: [0] framing, [1] parity, [2] break.
- `rx_empty`  out  1  FIFO empty.
- `rx_full`  out  1  FIFO full.
- `rx_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overrun`  out  1  sticky: a character was dropped because the FIFO was full.
- `rx_busy`  out  1  FSM is not in IDLE.
- `timeout_flag`  out  1  idle timeout with data pending.

## Operation
- **Synchroniser.** `UART_RXD` passes through a 2-flop synchroniser; both flops reset to 1.
- **Tick generator.** The divider counts 0..`baud_div` and emits a one-cycle tick at `baud_div`. With `baud_div=0`, a tick occurs every cycle.
- **FSM states.** IDLE → START → DATA → PARITY (only if `parity_en`) → STOP1 → STOP2 (only if `stop_bit_twice`) → IDLE.
- **IDLE.** A falling edge on the synchronised line while `rx_en=1` resets the divider and the tick-in-bit counter, then enters START.
- **Bit sampling.** Each bit's value is the majority of the samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- **START.** A sampled 1 is a false start; the FSM returns to IDLE and nothing is pushed.
- **DATA.** Data is received LSB first into the shift register. The bit count comes from `data_bits`, latched at the START transition.
- **Parity.** Even parity means the data bits XOR the parity bit equal 0; odd parity means they equal 1. A mismatch sets the parity error.
- **Stop bits.** A 0 sampled in STOP1, or in STOP2 when present, sets the framing error.
- **Break.** Break is set when all data bits, the parity bit (if present) and the STOP1 sample are all 0. Break also sets framing.
- **Frame end.** After the final stop-bit majority sample, the FSM pushes {err, data} and returns to IDLE at mid-bit, so the next start edge is accepted immediately.
- **FIFO push/pop.**
  - Push when full: the character is dropped and `overrun` is set. `overrun` stays set until `clr_errors`.
  - Push and `rd_en` in the same cycle while full: the pop takes effect and the push is accepted, with no overrun.
  - `rd_en` while empty is ignored.
- **FIFO read side.** The FIFO is first-word-fall-through. `rd_data`/`rd_err` are forced to 0 while `rx_empty=1`.
- **Pointers.** Pointers wrap modulo `FIFO_DEPTH`. Full versus empty is distinguished by an extra pointer MSB.
- **`rx_en` deasserted mid-frame.** The FSM returns to IDLE on the next cycle, the partial character is discarded, and the FIFO keeps its contents.
- **Configuration changes.** Frame-format inputs may change only while `rx_busy=0`.

## Timing
- **Reset values.** `rd_data`=0, `rd_err`=0, `rx_empty`=1, `rx_full`=0, `rx_level`=0, `overrun`=0, `rx_busy`=0, `timeout_flag`=0. FSM is in IDLE.
- **Pin to start detect.** 2 cycles of synchroniser latency plus 1 cycle for edge detection; `rx_busy` rises on the following cycle.
- **Push.** The push occurs one cycle after the cycle holding the final stop-bit mid tick. `rx_empty` falls and `rx_level` increments on the cycle after the push.
- **Pop.** The pop takes effect on the clock edge where `rd_en=1`. The new head is visible on the next cycle.
- **Bit period.** One bit is `(baud_div+1)*OVERSAMPLE` PCLK cycles.

## Configuration
- **`UART_RX_TIMEOUT_EN` defined.**
  - A counter increments on each tick while the FSM is in IDLE and the FIFO is non-empty.
  - It clears on `rd_en`, on a start edge, or when the FIFO becomes empty.
  - `timeout_flag` sets when the counter reaches `TIMEOUT_BITS*OVERSAMPLE`.
  - `timeout_flag` clears on the same events that clear the counter.
- **`UART_RX_TIMEOUT_EN` not defined.** No counter is built and `timeout_flag` is tied to 0.

## Structure
- **Package `uart_rx_pkg`:**
  - FSM state enum.
  - Error bit index constants (`ERR_FRAME`, `ERR_PARITY`, `ERR_BREAK`).
  - `data_bits` encoding.
  - Entry typedef {err[2:0], data[7:0]}.
- **Sub-module `uart_rx_fifo`:** synchronous FWFT FIFO parametrised by depth and entry width, with push, pop, full, empty and level.

## Test plan
Default parameters, `baud_div=3`, giving 64 PCLK per bit.

- **8N1 clean character.** Send 0xA5 with `data_bits=3`, no parity, one stop bit → after the stop mid-sample `rx_empty`=0, `rd_data`=0xA5, `rd_err`=0, `rx_level`=1.
- **7E1 parity error.** Send 0x35 in 7E1 with a forced parity bit of 1 → `rd_data`=0x35, `rd_err`=3'b010.
- **Break.** Hold the line low for 12 bit-times in 8N1 → one entry with `rd_data`=0x00 and `rd_err`=3'b101. No further push until the line returns high.
- **Overrun and full-pop corner.**
  - Push 17 characters without reading → `rx_full`=1, `rx_level`=16, `overrun`=1.
  - The 17th character is lost; the 1st is still at the head.
  - `clr_errors` clears `overrun`.
  - A push in the same cycle as `rd_en` while full → `rx_level` stays 16 and `overrun` stays 0.
- **False start and mid-frame disable.**
  - A 10-PCLK low glitch → `rx_busy` pulses and nothing is pushed.
  - Dropping `rx_en` at data bit 3 → IDLE on the next cycle and `rx_level` is unchanged.
- **Timeout (macro on).** One character received and not read → `timeout_flag`=1 exactly 32×16×4 PCLK after the FSM returns to IDLE; `rd_en` clears it on the next cycle.
